// File: rtl/weight_stream_ctrl_pkg.sv
// Shared definitions for the weight stream controller family: default
// kernel/coefficient sizes and the skid-buffer depth.
package weight_stream_ctrl_pkg;

  localparam int KERN_S_18   = 18;
  localparam int COEFF_WIDTH = 16;
  localparam int SKID_DEPTH  = 2;

endpackage

// File: rtl/wsc_skid_buf.sv
// Two-entry data buffer with push/pop and an occupancy count; the head word
// always sits in entry 0. The caller never pushes when full or pops when empty.
module wsc_skid_buf
  import weight_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = COEFF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] ent0_r;
  logic [DATA_WIDTH-1:0] ent1_r;
  logic [1:0]            count_r;

  // Storage update: a pop shifts entry 1 forward, a push fills the first free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_r  <= {DATA_WIDTH{1'b0}};
      ent1_r  <= {DATA_WIDTH{1'b0}};
      count_r <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) ent0_r <= din;
          else                 ent1_r <= din;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          ent0_r  <= ent1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            ent0_r <= din;
          end else begin
            ent0_r <= ent1_r;
            ent1_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign dout  = ent0_r;
  assign count = count_r;

endmodule

// File: rtl/weight_stream_ctrl.sv
// Streams MEM_SIZE ROM words per pass into a downstream FIFO with ap_* handshake.
// Optional feature macro WEIGHT_STREAM_REPEAT_EN: cfg_repeat+1 passes per job.
module weight_stream_ctrl
  import weight_stream_ctrl_pkg::*;
#(
  parameter int MEM_SIZE   = KERN_S_18,
  parameter int DATA_WIDTH = COEFF_WIDTH
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_idle,
  output logic                        ap_done,
  input  logic [7:0]                  cfg_repeat,
  output logic [$clog2(MEM_SIZE)-1:0] weight_V_address0,
  output logic                        weight_V_ce0,
  input  logic [DATA_WIDTH-1:0]       weight_V_q0,
  output logic [DATA_WIDTH-1:0]       output_V_din,
  input  logic                        output_V_full_n,
  output logic                        output_V_write
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_SIZE - 1);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]            state_r, state_nxt_s;
  logic [AW-1:0]         addr_r;
  logic [7:0]            pass_left_r;
  logic                  inflight_r;
  logic                  done_r;
  logic [1:0]            count_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [7:0]            passes_s;
  logic                  accept_s, pop_s, ce_s, last_rd_s, drained_s;

`ifdef WEIGHT_STREAM_REPEAT_EN
  assign passes_s = cfg_repeat;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^cfg_repeat;
  assign passes_s     = 8'd0;
`endif

  assign accept_s  = ap_start && (state_r == ST_IDLE);
  assign pop_s     = (count_s != 2'd0) && output_V_full_n;
  assign last_rd_s = ce_s && (addr_r == ADDR_LAST) && (pass_left_r == 8'd0);
  assign drained_s = !inflight_r && ((count_s == 2'd0) || ((count_s == 2'd1) && pop_s));

  wsc_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (inflight_r),
    .pop   (pop_s),
    .din   (weight_V_q0),
    .dout  (head_s),
    .count (count_s)
  );

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_r <= ST_IDLE;
    else           state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ap_start) state_nxt_s = ST_STREAM;
        else          state_nxt_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (last_rd_s) state_nxt_s = ST_DRAIN;
        else           state_nxt_s = ST_STREAM;
      end
      ST_DRAIN: begin
        if (drained_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Read issue: only when the word still has a buffer slot when it lands next cycle
  always_comb begin
    ce_s = 1'b0;
    if (state_r == ST_STREAM) begin
      ce_s = (({1'b0, count_s} + {2'b00, inflight_r}) - {2'b00, pop_s}) < 3'd2;
    end else begin
      ce_s = 1'b0;
    end
  end

  // Address, remaining passes, in-flight read and done pulse
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      addr_r      <= {AW{1'b0}};
      pass_left_r <= 8'd0;
      inflight_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      inflight_r <= ce_s;
      done_r     <= (state_r == ST_DRAIN) && drained_s;
      if (accept_s) begin
        addr_r      <= {AW{1'b0}};
        pass_left_r <= passes_s;
      end else if (ce_s) begin
        if (addr_r == ADDR_LAST) begin
          addr_r <= {AW{1'b0}};
          if (pass_left_r != 8'd0) pass_left_r <= pass_left_r - 8'd1;
        end else begin
          addr_r <= addr_r + AW'(1);
        end
      end
    end
  end

  assign ap_idle           = (state_r == ST_IDLE);
  assign ap_done           = done_r;
  assign weight_V_address0 = addr_r;
  assign weight_V_ce0      = ce_s;
  assign output_V_write    = pop_s;
  assign output_V_din      = head_s;

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench for weight_stream_ctrl with MEM_SIZE=8 and a 1-cycle ROM model.
module tb_weight_stream_ctrl;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic [7:0]  cfg_repeat;
  logic [2:0]  addr;
  logic        ce;
  logic [15:0] q0;
  logic [15:0] din;
  logic        full_n;
  logic        write;

  logic [15:0] rom [8];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 ap_clk = ~ap_clk;

  weight_stream_ctrl #(.MEM_SIZE(8), .DATA_WIDTH(16)) dut (
    .ap_clk            (ap_clk),
    .ap_rst_n          (ap_rst_n),
    .ap_start          (ap_start),
    .ap_idle           (ap_idle),
    .ap_done           (ap_done),
    .cfg_repeat        (cfg_repeat),
    .weight_V_address0 (addr),
    .weight_V_ce0      (ce),
    .weight_V_q0       (q0),
    .output_V_din      (din),
    .output_V_full_n   (full_n),
    .output_V_write    (write)
  );

  // ROM with one cycle read latency
  always @(posedge ap_clk) begin
    if (ce) q0 <= rom[addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one job starting at the current negedge (cycle 0); returns at the done cycle.
  task automatic run_job(input int nwords, input int stall_lo, input int stall_hi,
                         input bit rnd, input bit hold, input int exp_first, input int exp_done);
    int widx;
    int first_w;
    int done_c;
    widx = 0; first_w = -1; done_c = -1;
    ap_start = 1'b1;
    for (int c = 1; c <= 600 && done_c < 0; c++) begin
      @(negedge ap_clk);
      if (!hold) ap_start = 1'b0;
      if (rnd) full_n = 1'($urandom_range(0, 1));
      else     full_n = !(c >= stall_lo && c <= stall_hi);
      #1;
      if (c == 1) begin
        check_eq("ce_c1", 32'(ce), 32'd1);
        check_eq("addr_c1", 32'(addr), 32'd0);
        check_eq("busy_c1", 32'(ap_idle), 32'd0);
      end
      if (write) begin
        check_eq("wr_full", 32'(full_n), 32'd1);
        check_eq("din", 32'(din), 32'(rom[3'(widx % 8)]));
        if (widx == 0) first_w = c;
        widx++;
      end
      if (ap_done) begin
        done_c = c;
        check_eq("idle_at_done", 32'(ap_idle), 32'd1);
      end
    end
    check_eq("nwords", 32'(widx), 32'(nwords));
    check_eq("done_seen", 32'(done_c >= 0), 32'd1);
    if (exp_first >= 0) check_eq("first_wr", 32'(first_w), 32'(exp_first));
    if (exp_done >= 0)  check_eq("done_cyc", 32'(done_c), 32'(exp_done));
    full_n = 1'b1;
  endtask

  initial begin
    rom[0] = 16'hA001; rom[1] = 16'h3C02; rom[2] = 16'h5A03; rom[3] = 16'h7E04;
    rom[4] = 16'h0F05; rom[5] = 16'hC306; rom[6] = 16'h9907; rom[7] = 16'h6608;
    ap_rst_n = 1'b0; ap_start = 1'b0; cfg_repeat = 8'd0; full_n = 1'b1;
    #2;
    check_eq("rst_idle", 32'(ap_idle), 32'd1);
    check_eq("rst_done", 32'(ap_done), 32'd0);
    check_eq("rst_ce", 32'(ce), 32'd0);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_din", 32'(din), 32'd0);
    @(negedge ap_clk); @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Basic latency/throughput job
    run_job(8, 0, -1, 1'b0, 1'b0, 3, 11);
    // Backpressure in cycles 5..9
    run_job(8, 5, 9, 1'b0, 1'b0, 3, 16);
    // Repeat passes
    cfg_repeat = 8'd2;
`ifdef WEIGHT_STREAM_REPEAT_EN
    run_job(24, 0, -1, 1'b0, 1'b0, 3, 27);
`else
    run_job(8, 0, -1, 1'b0, 1'b0, 3, 11);
`endif
    cfg_repeat = 8'd0;
    // Random backpressure
    for (int j = 0; j < 1000; j++) run_job(8, 0, -1, 1'b1, 1'b0, -1, -1);

    // Reset in cycle 6 of a job
    ap_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
    end
    #1 ap_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_idle", 32'(ap_idle), 32'd1);
    check_eq("mid_rst_write", 32'(write), 32'd0);
    check_eq("mid_rst_ce", 32'(ce), 32'd0);
    check_eq("mid_rst_din", 32'(din), 32'd0);
    check_eq("mid_rst_done", 32'(ap_done), 32'd0);
    @(negedge ap_clk); @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    #1;
    check_eq("post_rst_idle", 32'(ap_idle), 32'd1);
    check_eq("post_rst_done", 32'(ap_done), 32'd0);
    check_eq("post_rst_ce", 32'(ce), 32'd0);
    run_job(8, 0, -1, 1'b0, 1'b0, 3, 11);

    // Start held high: back-to-back jobs accepted at each done cycle
    run_job(8, 0, -1, 1'b0, 1'b1, 3, 11);
    run_job(8, 0, -1, 1'b0, 1'b1, 3, 11);
    run_job(8, 0, -1, 1'b0, 1'b0, 3, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
